// File: rtl/time_cnt.sv
// mm:ss BCD time counter with RUN / SET_MIN / SET_SEC modes and per-digit blink blanking.
// Optional macro TIME_CNT_SEC_CLR_EN clears the seconds on the RUN -> SET_MIN transition.
module time_cnt #(
  parameter int unsigned MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_1hz,
  input  logic       mask_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  output logic [3:0] sec_l,
  output logic [3:0] sec_h,
  output logic [3:0] min_l,
  output logic [3:0] min_h,
  output logic [3:0] blank,
  output logic [1:0] mode,
  output logic       wrap
);

  typedef enum logic [1:0] {
    StRun    = 2'b00,
    StSetMin = 2'b01,
    StSetSec = 2'b10
  } state_e;

  localparam logic [3:0] MinMaxH = 4'(MIN_MAX / 10);
  localparam logic [3:0] MinMaxL = 4'(MIN_MAX % 10);

`ifdef TIME_CNT_SEC_CLR_EN
  localparam bit SecClrOnSet = 1'b1;
`else
  localparam bit SecClrOnSet = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [3:0] sec_l_q, sec_l_d, sec_h_q, sec_h_d;
  logic [3:0] min_l_q, min_l_d, min_h_q, min_h_d;
  logic [3:0] blank_q, blank_d;
  logic       wrap_q, wrap_d;

  logic [3:0] sec_inc_l, sec_inc_h, min_inc_l, min_inc_h;
  logic       sec_carry, min_at_max;

  // Incremented values; >= comparisons keep any stray code inside the legal range.
  always_comb begin
    sec_carry = 1'b0;
    sec_inc_l = sec_l_q + 4'd1;
    sec_inc_h = sec_h_q;
    if (sec_l_q >= 4'd9) begin
      sec_inc_l = 4'd0;
      if (sec_h_q >= 4'd5) begin
        sec_inc_h = 4'd0;
        sec_carry = 1'b1;
      end else begin
        sec_inc_h = sec_h_q + 4'd1;
      end
    end

    min_at_max = ({min_h_q, min_l_q} >= {MinMaxH, MinMaxL});
    min_inc_l  = min_l_q + 4'd1;
    min_inc_h  = min_h_q;
    if (min_at_max) begin
      min_inc_l = 4'd0;
      min_inc_h = 4'd0;
    end else if (min_l_q >= 4'd9) begin
      min_inc_l = 4'd0;
      min_inc_h = min_h_q + 4'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    sec_l_d = sec_l_q;
    sec_h_d = sec_h_q;
    min_l_d = min_l_q;
    min_h_d = min_h_q;
    wrap_d  = 1'b0;
    blank_d = 4'b0000;

    case (state_q)
      StRun: begin
        if (en_1hz) begin
          sec_l_d = sec_inc_l;
          sec_h_d = sec_inc_h;
          if (sec_carry) begin
            min_l_d = min_inc_l;
            min_h_d = min_inc_h;
            wrap_d  = min_at_max;
          end
        end
        // btn_up is ignored while running.
        if (btn_mode) begin
          state_d = StSetMin;
          if (SecClrOnSet) begin
            sec_l_d = 4'd0;
            sec_h_d = 4'd0;
          end
        end
      end
      StSetMin: begin
        if (btn_mode) begin
          state_d = StSetSec;
        end else if (btn_up) begin
          min_l_d = min_inc_l;
          min_h_d = min_inc_h;
        end
      end
      StSetSec: begin
        if (btn_mode) begin
          state_d = StRun;
        end else if (btn_up) begin
          sec_l_d = sec_inc_l;
          sec_h_d = sec_inc_h;
        end
      end
      default: state_d = StRun;
    endcase

    // Blank pattern follows the state being entered so it lines up with mode.
    case (state_d)
      StSetMin: blank_d = {mask_1hz, mask_1hz, 2'b00};
      StSetSec: blank_d = {2'b00, mask_1hz, mask_1hz};
      default:  blank_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StRun;
      sec_l_q <= 4'd0;
      sec_h_q <= 4'd0;
      min_l_q <= 4'd0;
      min_h_q <= 4'd0;
      blank_q <= 4'b0000;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sec_l_q <= sec_l_d;
      sec_h_q <= sec_h_d;
      min_l_q <= min_l_d;
      min_h_q <= min_h_d;
      blank_q <= blank_d;
      wrap_q  <= wrap_d;
    end
  end

  assign sec_l = sec_l_q;
  assign sec_h = sec_h_q;
  assign min_l = min_l_q;
  assign min_h = min_h_q;
  assign blank = blank_q;
  assign mode  = state_q;
  assign wrap  = wrap_q;

endmodule

// File: tb/tb_time_cnt.sv
// Scoreboard bench for time_cnt: an integer mm:ss model queues the expected outputs of
// each driven cycle, which are popped and compared one edge later.
module tb_time_cnt;

  localparam int MinMax = 59;

`ifdef TIME_CNT_SEC_CLR_EN
  localparam bit SecClr = 1'b1;
`else
  localparam bit SecClr = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_1hz = 1'b0, mask_1hz = 1'b0, btn_mode = 1'b0, btn_up = 1'b0;
  logic [3:0] sec_l, sec_h, min_l, min_h, blank;
  logic [1:0] mode;
  logic       wrap;

  time_cnt #(.MIN_MAX(MinMax)) dut (
    .clk      (clk),
    .rst      (rst),
    .en_1hz   (en_1hz),
    .mask_1hz (mask_1hz),
    .btn_mode (btn_mode),
    .btn_up   (btn_up),
    .sec_l    (sec_l),
    .sec_h    (sec_h),
    .min_l    (min_l),
    .min_h    (min_h),
    .blank    (blank),
    .mode     (mode),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sl, sh, ml, mh, bl, md, wr;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   m_min = 0, m_sec = 0, m_st = 0;

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Behavioural model on plain integers, then converted to digits.
  task automatic model(input bit m, input bit u, input bit e, input bit k);
    exp_t x;
    x.wr = 0;
    case (m_st)
      0: begin
        if (e) begin
          m_sec++;
          if (m_sec == 60) begin
            m_sec = 0;
            m_min++;
            if (m_min > MinMax) begin
              m_min = 0;
              x.wr = 1;
            end
          end
        end
        if (m) begin
          m_st = 1;
          if (SecClr) m_sec = 0;
        end
      end
      1: if (m) m_st = 2; else if (u) m_min = (m_min + 1) % (MinMax + 1);
      default: if (m) m_st = 0; else if (u) m_sec = (m_sec + 1) % 60;
    endcase
    x.sl = m_sec % 10;
    x.sh = m_sec / 10;
    x.ml = m_min % 10;
    x.mh = m_min / 10;
    x.md = m_st;
    x.bl = (m_st == 1) ? (k ? 12 : 0) : (m_st == 2) ? (k ? 3 : 0) : 0;
    exp_q.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    if (exp_q.size() == 0) begin
      check("queue_underflow", 0, 1);
      return;
    end
    x = exp_q.pop_front();
    check("sec_l", int'(sec_l), x.sl);
    check("sec_h", int'(sec_h), x.sh);
    check("min_l", int'(min_l), x.ml);
    check("min_h", int'(min_h), x.mh);
    check("blank", int'(blank), x.bl);
    check("mode", int'(mode), x.md);
    check("wrap", int'(wrap), x.wr);
  endtask

  // Called at posedge+1: drive, queue expectation, clock, compare.
  task automatic step(input bit m, input bit u, input bit e, input bit k);
    btn_mode = m;
    btn_up   = u;
    en_1hz   = e;
    mask_1hz = k;
    model(m, u, e, k);
    @(posedge clk);
    #1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    en_1hz   = 1'b0;
    compare_out();
  endtask

  task automatic set_min_to(input int target);
    for (int i = 0; i < 100 && m_min != target; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic set_sec_to(input int target);
    for (int i = 0; i < 100 && m_sec != target; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_digits"}, int'({min_h, min_l, sec_h, sec_l}), 0);
    check({tag, "_blank"}, int'(blank), 0);
    check({tag, "_mode"}, int'(mode), 0);
    check({tag, "_wrap"}, int'(wrap), 0);
  endtask

  // Asserts reset away from the clock edge; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check_zero(tag);
    en_1hz = 1'b1;
    btn_up = 1'b1;
    @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    en_1hz = 1'b0;
    btn_up = 1'b0;
    m_min = 0;
    m_sec = 0;
    m_st  = 0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3;
    check_zero("por");
    #5;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 61 seconds of running.
    repeat (61) step(1'b0, 1'b0, 1'b1, 1'b0);
    check("t61_mmss", int'({min_h, min_l, sec_h, sec_l}), 16'h0101);

    // Preload 59:59 and roll over.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_min_to(59);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_sec_to(59);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("preload", int'({min_h, min_l, sec_h, sec_l}), 16'h5959);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("rollover_wrap", int'(wrap), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("wrap_one_cycle", int'(wrap), 0);

    // SET_MIN: ups with en_1hz and mask toggling.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'(i % 2), 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("setmin_mm", int'({min_h, min_l}), 8'h03);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("setmin_blank", int'(blank), 4'b1100);

    // SET_SEC from 58: three ups wrap to 01, then mode beats up.
    step(1'b1, 1'b0, 1'b0, 1'b1);
    set_sec_to(58);
    repeat (3) step(1'b0, 1'b1, 1'b1, 1'b1);
    check("setsec_ss", int'({sec_h, sec_l}), 8'h01);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("mode_wins_mode", int'(mode), 0);
    check("mode_wins_ss", int'({sec_h, sec_l}), 8'h01);

    // Reset at 12:34 in SET_SEC.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_min_to(12);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_sec_to(34);
    do_reset("mid_rst");
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("first_tick", int'({min_h, min_l, sec_h, sec_l}), 16'h0001);

    // 05:37 then RUN -> SET_MIN; seconds cleared only with the macro.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_min_to(5);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    set_sec_to(37);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("sec_on_setmin", int'({sec_h, sec_l}), SecClr ? 0 : 8'h37);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    // Random mix, including simultaneous en_1hz and btn_mode in RUN.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/time_cnt.md
TIME_CNT -- requirements
Module: time_cnt

Interface
REQ-001 The block SHALL have parameter MIN_MAX, default 59, giving the maximum minute value; the legal range is 1..99, decimal.
REQ-002 Port clk  input  1  system clock, 100 MHz.
REQ-003 Port rst  input  1  reset, asynchronous and active-low: low = reset.
REQ-004 Port en_1hz  input  1  one-cycle count enable pulse, once per second.
REQ-005 Port mask_1hz  input  1  blink phase; 1 = blank a digit that is being set.
REQ-006 Port btn_mode  input  1  one-cycle pulse, debounced upstream, that advances the mode.
REQ-007 Port btn_up  input  1  one-cycle pulse, debounced upstream, that increments the field being set.
REQ-008 Port sec_l, sec_h, min_l, min_h  output  4 each  BCD digits of the mm:ss value.
REQ-009 Port blank  output  4  per-digit blank, ordered {min_h, min_l, sec_h, sec_l}.
REQ-010 Port mode  output  2  current state: 00 RUN, 01 SET_MIN, 10 SET_SEC.
REQ-011 Port wrap  output  1  one-cycle pulse when the count rolls over from MIN_MAX:59 to 00:00.

Function
REQ-012 The state machine SHALL have exactly three states, RUN, SET_MIN and SET_SEC; encoding 11 SHALL be unreachable and SHALL recover to RUN on the next clk.
REQ-013 A btn_mode pulse SHALL advance the state RUN -> SET_MIN -> SET_SEC -> RUN, one step per pulse.
REQ-014 In RUN, on en_1hz the seconds SHALL increment in BCD: sec_l 9 -> 0 carries into sec_h, and sec_h:sec_l 59 -> 00 carries into the minutes.
REQ-015 Minutes SHALL increment in BCD; MIN_MAX:59 plus one SHALL give 00:00, with wrap=1 for exactly that one cycle.
REQ-016 In SET_MIN and SET_SEC, en_1hz SHALL be ignored: the count freezes.
REQ-017 In SET_MIN, btn_up SHALL increment the minutes only; MIN_MAX wraps to 00 with no wrap pulse, and the seconds are untouched.
REQ-018 In SET_SEC, btn_up SHALL increment the seconds only; 59 wraps to 00 with no carry and no wrap pulse.
REQ-019 In RUN, btn_up SHALL be ignored.
REQ-020 If btn_mode and btn_up arrive in the same cycle, btn_mode SHALL win and btn_up SHALL be dropped.
REQ-021 If en_1hz and btn_mode arrive in the same cycle while in RUN, the increment SHALL apply and the state SHALL also advance.
REQ-022 blank SHALL be 0000 in RUN; in SET_MIN it SHALL equal {mask_1hz, mask_1hz, 0, 0}; in SET_SEC it SHALL equal {0, 0, mask_1hz, mask_1hz}.
REQ-023 Every output SHALL be registered, so each input event is visible one clk after the edge that samples it.
REQ-024 The digits SHALL never leave BCD 0..9, sec_h SHALL never leave 0..5, and minutes SHALL never exceed MIN_MAX.

Reset
REQ-025 While rst=0, all four digits, blank, mode and wrap SHALL be 0 immediately, independent of clk.
REQ-026 Reset asserted mid-operation (any state, any count) SHALL abort to RUN at 00:00 with no wrap pulse.
REQ-027 The first en_1hz sampled after rst rises SHALL give 00:01.

Configuration
REQ-028 With macro TIME_CNT_SEC_CLR_EN defined, the RUN -> SET_MIN transition SHALL clear the seconds to 00 on the same clk edge.
REQ-029 Without TIME_CNT_SEC_CLR_EN, the seconds SHALL be retained on the RUN -> SET_MIN transition.

Verification
REQ-030 Reset, then 61 en_1hz pulses -> 01:01, with wrap never asserted.
REQ-031 Preload 59:59 by set mode, return to RUN, then 1 en_1hz -> 00:00, with wrap=1 for exactly one cycle.
REQ-032 btn_mode once, then 3 btn_up with en_1hz toggling -> mode=01, minutes+3 mod 60, seconds unchanged, blank[3:2] following mask_1hz, blank[1:0]=00.
REQ-033 In SET_SEC at 58, 3 btn_up -> seconds 01, minutes unchanged; then btn_up and btn_mode in the same cycle -> mode=00, seconds 01.
REQ-034 Reset pulse at 12:34 in SET_SEC -> all outputs 0 within the same cycle, mode=00.
REQ-035 Build with and without TIME_CNT_SEC_CLR_EN, from 05:37 btn_mode -> seconds 00 if defined, 37 if not.
